// File: rtl/lcd_bus_writer.sv
// HD44780 byte writer: a 4-deep {rs, byte} FIFO drained by a pin sequencer that
// plays each word as setup, E pulse, hold and execution wait.
module lcd_bus_writer #(
   parameter int unsigned T_SETUP     = 10,
   parameter int unsigned T_E_HIGH    = 1000,
   parameter int unsigned T_E_LOW     = 1000,
   parameter int unsigned T_EXEC      = 5000,
   parameter int unsigned T_EXEC_LONG = 200000
) (
   input  logic       clk,
   input  logic       reset_btn,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_rs,
   input  logic [7:0] in_data,
   output logic       busy,
   output logic [2:0] fifo_count,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data
);

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;
   localparam int unsigned CNT_W = 32;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } word_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_E_HIGH = 3'd2,
      S_E_LOW  = 3'd3,
      S_EXEC   = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  timer;
   logic [CNT_W-1:0]  timer_nxt;
   word_t             fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push_c;
   logic              pop_c;
   logic              long_exec_c;
   logic [2:0]        count_nxt;
   logic              lcd_e_nxt;
   logic              lcd_rs_nxt;
   logic [7:0]        lcd_data_nxt;
   logic              busy_nxt;
   logic              in_ready_nxt;

   // Readiness uses the count before any same-cycle pop, so a full FIFO never accepts.
   assign push_c      = in_valid && (fifo_count < 3'(DEPTH));
   // Clear display and return home need the long execution wait.
   assign long_exec_c = !lcd_rs && (lcd_data inside {8'h01, 8'h02, 8'h03});

   // State register
   always_ff @(posedge clk) begin
      if (!reset_btn) begin
         state <= S_IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   // Next-state and phase timer
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      pop_c     = 1'b0;
      case (state)
         S_IDLE: begin
            if (fifo_count != 3'd0) begin
               pop_c     = 1'b1;
               state_nxt = S_SETUP;
               timer_nxt = CNT_W'(T_SETUP - 1);
            end
         end
         S_SETUP: begin
            if (timer == '0) begin
               state_nxt = S_E_HIGH;
               timer_nxt = CNT_W'(T_E_HIGH - 1);
            end else begin
               timer_nxt = timer - CNT_W'(1);
            end
         end
         S_E_HIGH: begin
            if (timer == '0) begin
               state_nxt = S_E_LOW;
               timer_nxt = CNT_W'(T_E_LOW - 1);
            end else begin
               timer_nxt = timer - CNT_W'(1);
            end
         end
         S_E_LOW: begin
            if (timer == '0) begin
               state_nxt = S_EXEC;
               timer_nxt = long_exec_c ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
            end else begin
               timer_nxt = timer - CNT_W'(1);
            end
         end
         S_EXEC: begin
            if (timer == '0) begin
               state_nxt = S_IDLE;
            end else begin
               timer_nxt = timer - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
         end
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      count_nxt    = fifo_count;
      lcd_rs_nxt   = lcd_rs;
      lcd_data_nxt = lcd_data;
      if (push_c && !pop_c) begin
         count_nxt = fifo_count + 3'd1;
      end else if (!push_c && pop_c) begin
         count_nxt = fifo_count - 3'd1;
      end
      if (pop_c) begin
         lcd_rs_nxt   = fifo_mem[rd_ptr].rs;
         lcd_data_nxt = fifo_mem[rd_ptr].data;
      end
      lcd_e_nxt    = (state_nxt == S_E_HIGH);
      busy_nxt     = (count_nxt != 3'd0) || (state_nxt != S_IDLE);
      in_ready_nxt = (count_nxt < 3'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         fifo_mem[wr_ptr] <= '{rs: in_rs, data: in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_btn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= 3'd0;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_rw     <= 1'b0;
         lcd_e      <= 1'b0;
         lcd_data   <= 8'h00;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         fifo_count <= count_nxt;
         in_ready   <= in_ready_nxt;
         busy       <= busy_nxt;
         lcd_rs     <= lcd_rs_nxt;
         lcd_rw     <= 1'b0;
         lcd_e      <= lcd_e_nxt;
         lcd_data   <= lcd_data_nxt;
      end
   end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Randomized bench for lcd_bus_writer against a timeline model: each accepted word
// is assigned its pop edge arithmetically, from which E pulses, busy and fill follow.
module tb_lcd_bus_writer;

   localparam int TS  = 2;
   localparam int TH  = 4;
   localparam int TL  = 4;
   localparam int TX  = 8;
   localparam int TXL = 32;

   logic       clk = 1'b0;
   logic       reset_btn;
   logic       in_valid;
   logic       in_ready;
   logic       in_rs;
   logic [7:0] in_data;
   logic       busy;
   logic [2:0] fifo_count;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic [7:0] lcd_data;

   lcd_bus_writer #(
      .T_SETUP(TS), .T_E_HIGH(TH), .T_E_LOW(TL), .T_EXEC(TX), .T_EXEC_LONG(TXL)
   ) dut (
      .clk(clk), .reset_btn(reset_btn), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_data(in_data), .busy(busy), .fifo_count(fifo_count),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // Timeline model: per accepted word, its push edge, pop edge and return-to-idle edge
   int         m_push[$];
   int         m_pop[$];
   int         m_idle[$];
   logic [8:0] m_word[$];
   int         next_free = 0;

   // Observed E pulses
   int         mon_rise[$];
   logic [8:0] mon_word[$];
   int         mon_width[$];
   int         unstable = 0;
   bit         prev_e = 1'b0;
   int         hi_len = 0;
   logic [8:0] hold_w = '0;

   always @(negedge clk) begin
      if (lcd_e === 1'b1 && !prev_e) begin
         mon_rise.push_back(cyc);
         mon_word.push_back({lcd_rs, lcd_data});
         hold_w = {lcd_rs, lcd_data};
         hi_len = 1;
      end else if (lcd_e === 1'b1) begin
         hi_len++;
         if ({lcd_rs, lcd_data} !== hold_w) unstable++;
      end
      if (lcd_e !== 1'b1 && prev_e) mon_width.push_back(hi_len);
      prev_e = (lcd_e === 1'b1);
   end

   function automatic int exec_of(input logic [8:0] w);
      if (!w[8] && (w[7:0] == 8'h01 || w[7:0] == 8'h02 || w[7:0] == 8'h03)) return TXL;
      return TX;
   endfunction

   function automatic int spacing(input logic [8:0] w);
      return 1 + TS + TH + TL + exec_of(w);
   endfunction

   task automatic model_push(input logic [8:0] w, input int pe);
      int pop;
      pop = (pe + 1 > next_free) ? pe + 1 : next_free;
      next_free = pop + spacing(w);
      m_push.push_back(pe);
      m_pop.push_back(pop);
      m_idle.push_back(pop + spacing(w) - 1);
      m_word.push_back(w);
   endtask

   function automatic int model_count(input int n);
      int c = 0;
      for (int i = 0; i < m_push.size(); i++)
         if (m_push[i] <= n && m_pop[i] > n) c++;
      return c;
   endfunction

   function automatic bit model_busy(input int n);
      for (int i = 0; i < m_push.size(); i++)
         if (m_push[i] <= n && n < m_idle[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit model_e(input int n);
      for (int i = 0; i < m_pop.size(); i++)
         if (m_pop[i] + TS <= n && n < m_pop[i] + TS + TH) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_clear;
      m_push.delete(); m_pop.delete(); m_idle.delete(); m_word.delete();
      mon_rise.delete(); mon_word.delete(); mon_width.delete();
      next_free = 0;
      unstable  = 0;
   endtask

   // Called at a negedge; holds the word until the model says the FIFO takes it
   task automatic drive_word(input logic rs, input logic [7:0] d);
      int guard = 0;
      in_valid = 1'b1; in_rs = rs; in_data = d;
      while (model_count(cyc) >= 4 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      model_push({rs, d}, cyc);
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset_btn = 1'b0; in_valid = 1'b0; in_rs = 1'b0; in_data = 8'h00;
      repeat (3) @(negedge clk);
      reset_btn = 1'b1;
      @(negedge clk);
      n_cmp++; if (lcd_e !== 1'b0) begin n_bad++; $display("FAIL reset_lcd_e got %b want 0", lcd_e); end
      n_cmp++; if (lcd_data !== 8'h00) begin n_bad++; $display("FAIL reset_lcd_data got %h want 00", lcd_data); end
      n_cmp++; if (lcd_rs !== 1'b0) begin n_bad++; $display("FAIL reset_lcd_rs got %b want 0", lcd_rs); end
      n_cmp++; if (lcd_rw !== 1'b0) begin n_bad++; $display("FAIL reset_lcd_rw got %b want 0", lcd_rw); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_single_write;
      int pe, rise_at = -1, low_at = -1;
      model_clear;
      drive_word(1'b1, 8'h41);
      in_valid = 1'b0;
      pe = cyc;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (k == 0) begin
            n_cmp++;
            if ({lcd_rs, lcd_data} !== 9'h141) begin
               n_bad++; $display("FAIL single_pins got rs=%b data=%h want rs=1 data=41", lcd_rs, lcd_data);
            end
         end
         if (lcd_e === 1'b1 && rise_at < 0) rise_at = cyc;
         if (busy === 1'b0 && low_at < 0) low_at = cyc;
         n_cmp++;
         if (lcd_e !== model_e(cyc)) begin n_bad++; $display("FAIL single_lcd_e cyc=%0d got %b want %b", cyc, lcd_e, model_e(cyc)); end
         n_cmp++;
         if (busy !== model_busy(cyc)) begin n_bad++; $display("FAIL single_busy cyc=%0d got %b want %b", cyc, busy, model_busy(cyc)); end
      end
      n_cmp++; if (rise_at - pe !== 3) begin n_bad++; $display("FAIL single_e_rise got +%0d want +3", rise_at - pe); end
      n_cmp++; if (low_at - pe !== 19) begin n_bad++; $display("FAIL single_busy_low got +%0d want +19", low_at - pe); end
      n_cmp++; if (mon_width.size() != 1 || mon_width[0] !== TH) begin n_bad++; $display("FAIL single_e_width got n=%0d w=%0d want w=%0d", mon_width.size(), mon_width[0], TH); end
   endtask

   task automatic test_back_to_back;
      bit ok;
      model_clear;
      drive_word(1'b0, 8'h38);
      drive_word(1'b0, 8'h0C);
      drive_word(1'b0, 8'h06);
      in_valid = 1'b0;
      wait_idle(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
      n_cmp++; if (mon_rise.size() != 3) begin n_bad++; $display("FAIL b2b_pulse_count got %0d want 3", mon_rise.size()); end
      for (int i = 0; i < 3 && i < mon_rise.size(); i++) begin
         n_cmp++;
         if (mon_word[i] !== m_word[i] || mon_rise[i] !== m_pop[i] + TS || mon_width[i] !== TH) begin
            n_bad++;
            $display("FAIL b2b_pulse[%0d] got word=%h rise=%0d width=%0d want word=%h rise=%0d width=%0d",
                     i, mon_word[i], mon_rise[i], mon_width[i], m_word[i], m_pop[i] + TS, TH);
         end
      end
      n_cmp++; if (mon_rise[1] - mon_rise[0] !== 19) begin n_bad++; $display("FAIL b2b_gap01 got %0d want 19", mon_rise[1] - mon_rise[0]); end
      n_cmp++; if (mon_rise[2] - mon_rise[1] !== 19) begin n_bad++; $display("FAIL b2b_gap12 got %0d want 19", mon_rise[2] - mon_rise[1]); end
      n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL b2b_data_stable got %0d changes want 0", unstable); end
   endtask

   task automatic test_long_exec;
      bit ok;
      logic [7:0] code;
      code = 8'($urandom_range(1, 3));
      model_clear;
      drive_word(1'b0, code);
      drive_word(1'b1, 8'h41);
      in_valid = 1'b0;
      wait_idle(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL long_idle got busy=%b want 0", busy); end
      n_cmp++;
      if (mon_rise.size() != 2 || mon_rise[1] - mon_rise[0] !== 43) begin
         n_bad++; $display("FAIL long_gap cmd=%h got n=%0d gap=%0d want gap 43", code, mon_rise.size(), mon_rise[1] - mon_rise[0]);
      end
      n_cmp++; if (mon_word[0] !== {1'b0, code}) begin n_bad++; $display("FAIL long_word got %h want %h", mon_word[0], {1'b0, code}); end
      model_clear;
      drive_word(1'b1, code);
      drive_word(1'b0, 8'h38);
      in_valid = 1'b0;
      wait_idle(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL short_idle got busy=%b want 0", busy); end
      n_cmp++;
      if (mon_rise.size() != 2 || mon_rise[1] - mon_rise[0] !== 19) begin
         n_bad++; $display("FAIL short_gap data=%h got n=%0d gap=%0d want gap 19", code, mon_rise.size(), mon_rise[1] - mon_rise[0]);
      end
   endtask

   task automatic test_full;
      logic [8:0] w [6];
      int k = 0, guard = 0;
      bit exp_rdy, saw_full = 1'b0, ok;
      model_clear;
      for (int i = 0; i < 6; i++) w[i] = {1'($urandom_range(0, 1)), 8'($urandom)};
      in_valid = 1'b1; in_rs = w[0][8]; in_data = w[0][7:0];
      while (k < 6 && guard < 2000) begin
         exp_rdy = (model_count(cyc) < 4);
         n_cmp++;
         if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL full_in_ready cyc=%0d got %b want %b", cyc, in_ready, exp_rdy); end
         n_cmp++;
         if (fifo_count !== 3'(model_count(cyc))) begin
            n_bad++; $display("FAIL full_fifo_count cyc=%0d got %0d want %0d", cyc, fifo_count, model_count(cyc));
         end
         if (!exp_rdy) saw_full = 1'b1;
         @(negedge clk);
         guard++;
         if (exp_rdy) begin
            model_push(w[k], cyc);
            k++;
            if (k < 6) begin in_rs = w[k][8]; in_data = w[k][7:0]; end
         end
      end
      in_valid = 1'b0;
      n_cmp++; if (saw_full !== 1'b1) begin n_bad++; $display("FAIL full_reached got %b want 1", saw_full); end
      wait_idle(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_idle got busy=%b want 0", busy); end
      n_cmp++; if (mon_rise.size() != 6) begin n_bad++; $display("FAIL full_pulse_count got %0d want 6", mon_rise.size()); end
      for (int i = 0; i < 6 && i < mon_rise.size(); i++) begin
         n_cmp++;
         if (mon_word[i] !== m_word[i] || mon_rise[i] !== m_pop[i] + TS) begin
            n_bad++;
            $display("FAIL full_pulse[%0d] got word=%h rise=%0d want word=%h rise=%0d",
                     i, mon_word[i], mon_rise[i], m_word[i], m_pop[i] + TS);
         end
      end
   endtask

   task automatic test_random_stream;
      bit ok;
      logic rs;
      logic [7:0] d;
      model_clear;
      for (int i = 0; i < 10; i++) begin
         rs = 1'($urandom_range(0, 1));
         d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
         drive_word(rs, d);
         in_valid = 1'b0;
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      wait_idle(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand_idle got busy=%b want 0", busy); end
      n_cmp++; if (mon_rise.size() != m_pop.size()) begin n_bad++; $display("FAIL rand_pulse_count got %0d want %0d", mon_rise.size(), m_pop.size()); end
      for (int i = 0; i < mon_rise.size() && i < m_pop.size(); i++) begin
         n_cmp++;
         if (mon_word[i] !== m_word[i] || mon_rise[i] !== m_pop[i] + TS || mon_width[i] !== TH) begin
            n_bad++;
            $display("FAIL rand_pulse[%0d] got word=%h rise=%0d width=%0d want word=%h rise=%0d width=%0d",
                     i, mon_word[i], mon_rise[i], mon_width[i], m_word[i], m_pop[i] + TS, TH);
         end
      end
      n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL rand_data_stable got %0d changes want 0", unstable); end
   endtask

   task automatic test_reset_mid;
      int target;
      model_clear;
      drive_word(1'b1, 8'($urandom));
      drive_word(1'b1, 8'($urandom));
      drive_word(1'b0, 8'h38);
      in_valid = 1'b0;
      target = m_pop[0] + TS + 1;
      while (cyc < target) @(negedge clk);
      n_cmp++; if (lcd_e !== 1'b1) begin n_bad++; $display("FAIL mid_e_high got %b want 1", lcd_e); end
      n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL mid_queued got %0d want 2", fifo_count); end
      reset_btn = 1'b0;
      @(negedge clk);
      n_cmp++; if (lcd_e !== 1'b0) begin n_bad++; $display("FAIL mid_reset_e got %b want 0", lcd_e); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_reset_count got %0d want 0", fifo_count); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy got %b want 0", busy); end
      reset_btn = 1'b1;
      model_clear;
      repeat (80) @(negedge clk);
      n_cmp++; if (mon_rise.size() != 0) begin n_bad++; $display("FAIL mid_no_pulse got %0d pulses want 0", mon_rise.size()); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_after_busy got %b want 0", busy); end
      n_cmp++; if (lcd_data !== 8'h00) begin n_bad++; $display("FAIL mid_after_data got %h want 00", lcd_data); end
   endtask

   initial begin
      test_reset;
      test_single_write;
      test_back_to_back;
      test_long_exec;
      test_full;
      test_random_stream;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
